// File: rtl/shape_select_ctrl_if.sv
// Bus between the shape-select controller and its surroundings.
//   Buttons/frame_start : raw push-buttons (async, active-high) and the one-clk
//                         frame pulse from VGA sync.
//   *_select            : one-hot grid selection, idx 0..8 in row-major order.
//   full_screen         : selected shape shown full screen.
// slave = controller side, master = stimulus/consumer side.
interface shape_select_ctrl_if;
    logic btn_up;
    logic btn_down;
    logic btn_left;
    logic btn_right;
    logic btn_enter;
    logic frame_start;
    logic circle_select;
    logic square_select;
    logic triangle_select;
    logic oval_select;
    logic rectangle_select;
    logic diamond_select;
    logic hexagon_select;
    logic pentagon_select;
    logic star_select;
    logic full_screen;

    modport slave (
        input  btn_up, btn_down, btn_left, btn_right, btn_enter, frame_start,
        output circle_select, square_select, triangle_select, oval_select,
               rectangle_select, diamond_select, hexagon_select, pentagon_select,
               star_select, full_screen
    );

    modport master (
        output btn_up, btn_down, btn_left, btn_right, btn_enter, frame_start,
        input  circle_select, square_select, triangle_select, oval_select,
               rectangle_select, diamond_select, hexagon_select, pentagon_select,
               star_select, full_screen
    );
endinterface

// File: rtl/shape_select_ctrl.sv
// Shape-select controller: debounces five buttons, moves a cursor over the
// 3x3 shape grid, toggles full-screen mode, and presents the selection to the
// renderer only on frame_start so a frame never mixes two selections.
//   clk, rst_n : single clock, async active-low reset
//   bus        : shape_select_ctrl_if.slave (buttons, frame_start, selects, full_screen)

// One button: 2-FF sync, hold-time debounce, rising-edge event pulse.
module shape_select_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 19
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic evt
);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1, sync2;
    logic             stable, stable_d;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            stable   <= 1'b0;
            stable_d <= 1'b0;
            cnt      <= '0;
        end else begin
            sync1    <= raw;
            sync2    <= sync1;
            stable_d <= stable;
            // Any agreement with the stable level restarts the hold count,
            // so a bounce shorter than DEBOUNCE_CYCLES never gets through.
            if (sync2 == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                stable <= sync2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // Press only; release produces no event.
    assign evt = stable & ~stable_d;
endmodule

module shape_select_ctrl #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 19
) (
    input logic                 clk,
    input logic                 rst_n,
    shape_select_ctrl_if.slave  bus
);
    localparam int NUM_BTN = 5;
    localparam int B_UP    = 0;
    localparam int B_DOWN  = 1;
    localparam int B_LEFT  = 2;
    localparam int B_RIGHT = 3;
    localparam int B_ENTER = 4;

    typedef enum logic {GRID, FULL} state_t;

    logic [NUM_BTN-1:0] raw, evt;
    state_t             state;
    logic [1:0]         row, col;
    logic [3:0]         shadow_idx;
    logic [8:0]         shadow_sel;
    logic [8:0]         sel_q;
    logic               full_q;

    assign raw = {bus.btn_enter, bus.btn_right, bus.btn_left, bus.btn_down, bus.btn_up};

    for (genvar b = 0; b < NUM_BTN; b++) begin : g_btn
        shape_select_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_db (
            .clk   (clk),
            .rst_n (rst_n),
            .raw   (raw[b]),
            .evt   (evt[b])
        );
    end

    function automatic logic [1:0] inc3(input logic [1:0] v);
        return (v == 2'd2) ? 2'd0 : v + 2'd1;
    endfunction

    function automatic logic [1:0] dec3(input logic [1:0] v);
        return (v == 2'd0) ? 2'd2 : v - 2'd1;
    endfunction

    // Cursor/mode FSM. The if/else chain is the event priority:
    // enter > up > down > left > right; losers in the same clk are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= GRID;
            row   <= 2'd0;
            col   <= 2'd0;
        end else if (evt[B_ENTER]) begin
            state <= (state == GRID) ? FULL : GRID;
        end else if (state == GRID) begin
            if      (evt[B_UP])    row <= dec3(row);
            else if (evt[B_DOWN])  row <= inc3(row);
            else if (evt[B_LEFT])  col <= dec3(col);
            else if (evt[B_RIGHT]) col <= inc3(col);
        end
    end

    assign shadow_idx = 4'(row) * 4'd3 + 4'(col);
    assign shadow_sel = 9'b1 << shadow_idx;

    // Outputs follow the shadow only at frame_start. An event in the same
    // clk updates row/col/state concurrently, so the frame takes the
    // pre-event view and the change shows at the following frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q  <= 9'b1;
            full_q <= 1'b0;
        end else if (bus.frame_start) begin
            sel_q  <= shadow_sel;
            full_q <= (state == FULL);
        end
    end

    assign bus.circle_select    = sel_q[0];
    assign bus.square_select    = sel_q[1];
    assign bus.triangle_select  = sel_q[2];
    assign bus.oval_select      = sel_q[3];
    assign bus.rectangle_select = sel_q[4];
    assign bus.diamond_select   = sel_q[5];
    assign bus.hexagon_select   = sel_q[6];
    assign bus.pentagon_select  = sel_q[7];
    assign bus.star_select      = sel_q[8];
    assign bus.full_screen      = full_q;
endmodule
